ifu_axi_fetch_master: RTL and testbench
=======================================

// Module: ifu_axi_fetch_master
// PURPOSE
//  Instruction-fetch AXI read master. Owns the PC and issues one AR request per instruction to the
//  IFU AXI slave (pmem). Extracts the 32-bit instruction from the 64-bit beat and hands {pc, inst}
//  to the ID stage over a valid/ready handshake. Accepts EXU redirects and flushes in-flight fetches.
// PARAMETERS
//  RESET_PC  64'h8000_0000  first fetch address after reset
//  ADDR_W    64             AXI address / PC width
//  DATA_W    64             AXI read data width
// PORTS
//  clk             in   1       single clock, all logic on posedge
//  rst             in   1       synchronous reset, active-high
//  ifu_ar_addr     out  ADDR_W  read address: request PC & ~7 (8-byte aligned)
//  ifu_ar_valid    out  1       read address valid
//  ifu_ar_ready    in   1       read address ready
//  ifu_r_data      in   DATA_W  read data beat
//  ifu_r_resp      in   2       read response, 2'b00 = OKAY
//  ifu_r_valid     in   1       read data valid
//  ifu_r_ready     out  1       read data ready
//  redirect_valid  in   1       EXU branch/jump/trap redirect, one-cycle pulse
//  redirect_pc     in   ADDR_W  redirect target; bits [1:0] ignored (treated as 0)
//  id_valid        out  1       instruction valid to ID
//  id_ready        in   1       ID accepts instruction
//  id_pc           out  ADDR_W  PC of presented instruction
//  id_inst         out  32      instruction word
//  id_fault        out  1       fetch response was not OKAY
// BEHAVIOUR
//  - Registers: pc, req_addr, inst_q, fault_q, drop, state. Outputs decoded from state/regs only.
//  - Reset: state=IDLE, pc=RESET_PC, drop=0; ar_valid=0, r_ready=0, id_valid=0, id_inst=0, id_fault=0.
//  - FSM: IDLE -> REQ unconditionally next cycle (req_addr <= pc on entry to REQ, every entry).
//    REQ : ar_valid=1, ar_addr=req_addr&~7; on ar_valid&ar_ready -> RESP.
//    RESP: r_ready=1; on r_valid&r_ready: if drop|redirect_valid -> discard beat, drop<=0, -> REQ;
//          else inst_q <= pc[2] ? r_data[63:32] : r_data[31:0], fault_q <= (r_resp!=0), -> HOLD.
//    HOLD: id_valid=1, id_pc=pc, id_inst=inst_q, id_fault=fault_q; on id_valid&id_ready ->
//          pc<=pc+4, -> REQ.
//  - AXI rule: ar_addr constant while ar_valid&~ar_ready; never changed by redirect.
//  - Redirect (priority over all other pc updates): pc <= {redirect_pc[ADDR_W-1:2],2'b00}, and
//    IDLE: stay course (-> REQ, fetches new pc).
//    REQ : drop<=1 (outstanding/issuing request completes, its beat is discarded), state per FSM.
//    RESP without r handshake: drop<=1. RESP with r handshake same cycle: beat discarded, drop stays 0.
//    HOLD: held instruction killed, -> REQ (same-cycle id handshake ignored; ID is flushed too).
//  - Only one outstanding AR at a time; no new AR until current beat accepted.
//  - Min latency: AR handshake cycle N, R handshake >= N+1, id_valid >= N+2; next AR after id accept+1.
//  - pc wraps modulo 2^ADDR_W on +4. rst mid-transaction: abandon all state, return to reset values.
// TESTING
//  1 Reset release, ar_ready=1 -> cycle after IDLE: ar_valid=1, ar_addr=0x8000_0000.
//  2 pc=0x8000_0004, r_data=0x1111_2222_3333_4444 -> ar_addr=0x8000_0000, id_inst=0x1111_2222, id_pc=0x8000_0004.
//  3 id_ready low 5 cycles in HOLD -> id_valid/id_inst stable, ar_valid=0 throughout; accept -> next ar_addr=pc+4.
//  4 redirect to 0x8000_1000 during RESP (r_valid delayed 3 cycles) -> old beat discarded, no id_valid, next ar_addr=0x8000_1000.
//  5 redirect while ar_valid&~ar_ready -> ar_addr held at old value until handshake, beat dropped, then REQ 0x8000_1000.
//  6 r_resp=2'b10 -> id_valid with id_fault=1; OKAY fetch after -> id_fault=0.

Source files
------------

// File: rtl/ifu_axi_fetch_master.sv
// Instruction-fetch AXI read master: owns the PC, issues one 8-byte-aligned AR per
// instruction, extracts the 32-bit word and presents {pc, inst, fault} to ID.
module ifu_axi_fetch_master #(
  parameter int                ADDR_W   = 64,
  parameter int                DATA_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] ifu_ar_addr,
  output logic              ifu_ar_valid,
  input  logic              ifu_ar_ready,
  input  logic [DATA_W-1:0] ifu_r_data,
  input  logic [1:0]        ifu_r_resp,
  input  logic              ifu_r_valid,
  output logic              ifu_r_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [31:0]       id_inst,
  output logic              id_fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, r_req_addr, w_pc_nxt, w_redir_pc;
  logic [31:0]       r_inst;
  logic              r_fault, r_drop;
  logic              w_ar_hs, w_r_hs, w_id_hs;

  assign w_redir_pc = redirect_pc & ~ADDR_W'(3);
  assign w_ar_hs    = (r_state == S_REQ)  && ifu_ar_ready;
  assign w_r_hs     = (r_state == S_RESP) && ifu_r_valid;
  assign w_id_hs    = (r_state == S_HOLD) && id_ready;

  always_comb begin
    w_pc_nxt = r_pc;
    if (redirect_valid)
      w_pc_nxt = w_redir_pc;
    else if (w_id_hs)
      w_pc_nxt = r_pc + ADDR_W'(4);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ:  if (w_ar_hs) w_state_nxt = S_RESP;
      // A beat belonging to a redirected-away fetch goes straight back to REQ.
      S_RESP: if (w_r_hs) w_state_nxt = (r_drop || redirect_valid) ? S_REQ : S_HOLD;
      S_HOLD: if (redirect_valid || id_ready) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_inst     <= '0;
      r_fault    <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      // Latch the fetch address only on entry so AR stays stable while stalled.
      if (w_state_nxt == S_REQ && r_state != S_REQ)
        r_req_addr <= w_pc_nxt;
      if (w_r_hs)
        r_drop <= 1'b0;
      else if (redirect_valid && (r_state == S_REQ || r_state == S_RESP))
        r_drop <= 1'b1;
      if (w_r_hs && !r_drop && !redirect_valid) begin
        r_inst  <= r_pc[2] ? ifu_r_data[63:32] : ifu_r_data[31:0];
        r_fault <= (ifu_r_resp != 2'b00);
      end
    end
  end

  assign ifu_ar_valid = (r_state == S_REQ);
  assign ifu_ar_addr  = {r_req_addr[ADDR_W-1:3], 3'b000};
  assign ifu_r_ready  = (r_state == S_RESP);
  assign id_valid     = (r_state == S_HOLD);
  assign id_pc        = r_pc;
  assign id_inst      = r_inst;
  assign id_fault     = r_fault;

endmodule

// File: tb/tb_ifu_axi_fetch_master.sv
// Bench for ifu_axi_fetch_master: random AXI slave / ID / redirect traffic against an
// architectural model of the expected accepted-instruction stream.
module tb_ifu_axi_fetch_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] ifu_ar_addr;
  logic        ifu_ar_valid;
  logic        ifu_ar_ready = 1'b0;
  logic [63:0] ifu_r_data = '0;
  logic [1:0]  ifu_r_resp = '0;
  logic        ifu_r_valid = 1'b0;
  logic        ifu_r_ready;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic        id_fault;

  ifu_axi_fetch_master dut (
    .clk(clk), .rst(rst),
    .ifu_ar_addr(ifu_ar_addr), .ifu_ar_valid(ifu_ar_valid), .ifu_ar_ready(ifu_ar_ready),
    .ifu_r_data(ifu_r_data), .ifu_r_resp(ifu_r_resp), .ifu_r_valid(ifu_r_valid),
    .ifu_r_ready(ifu_r_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .id_fault(id_fault)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, n_acc = 0;
  int p_arr = 100, p_idr = 100, p_redir = 0, rmin = 0, rmax = 0;
  int redir_when = 0;
  logic [63:0] redir_tgt = '0;

  // slave / monitor state
  int          out_cnt = 0, beat_dly = 0;
  bit          clr_r = 0, prev_ar_stall = 0;
  logic [63:0] beat_addr = '0, prev_ar_addr = '0, exp_pc = 64'h8000_0000;
  logic        s_ar_valid, s_r_ready, s_id_valid, s_id_fault;
  logic [63:0] s_ar_addr, s_id_pc;
  logic [31:0] s_id_inst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem(input logic [63:0] a);
    logic [63:0] b;
    b = a & ~64'h7;
    if (b == 64'h8000_0000) return 64'h1111_2222_3333_4444;
    return {b[31:0] ^ b[63:32] ^ 32'h5A5A_1234, b[34:3] * 32'h9E37_79B1};
  endfunction

  function automatic bit is_err(input logic [63:0] a);
    return a[5:3] == 3'b010;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] pc);
    logic [63:0] w;
    w = mem(pc);
    return pc[2] ? w[63:32] : w[31:0];
  endfunction

  function automatic logic [63:0] rand_tgt();
    case ($urandom_range(2))
      0:       return 64'h8000_0000 | 64'($urandom_range(16'hFFFF));
      1:       return 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(31));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One clock: sample outputs, drive inputs for this cycle, then apply this cycle's handshakes.
  task automatic step();
    @(negedge clk);
    s_ar_valid = ifu_ar_valid; s_ar_addr = ifu_ar_addr; s_r_ready = ifu_r_ready;
    s_id_valid = id_valid; s_id_pc = id_pc; s_id_inst = id_inst; s_id_fault = id_fault;
    if (prev_ar_stall) begin
      chk("ar_hold_valid", 64'(s_ar_valid), 64'(1));
      chk("ar_hold_addr", s_ar_addr, prev_ar_addr);
    end
    if (s_id_valid) chk("ar_in_hold", 64'(s_ar_valid), 64'(0));

    ifu_ar_ready = ($urandom_range(99) < p_arr);
    if (clr_r) begin ifu_r_valid = 1'b0; clr_r = 0; end
    if (out_cnt > 0 && !ifu_r_valid) begin
      if (beat_dly == 0) begin
        ifu_r_valid = 1'b1;
        ifu_r_data  = mem(beat_addr);
        ifu_r_resp  = is_err(beat_addr) ? 2'b10 : 2'b00;
      end else beat_dly--;
    end
    if (!ifu_r_valid) begin
      ifu_r_data = {$urandom, $urandom};
      ifu_r_resp = 2'($urandom_range(3));
    end
    id_ready = ($urandom_range(99) < p_idr);
    redirect_valid = 1'b0;
    redirect_pc = {$urandom, $urandom};
    if ((redir_when == 1 && s_r_ready && !ifu_r_valid) ||
        (redir_when == 2 && s_ar_valid && !ifu_ar_ready) || redir_when == 3) begin
      redirect_valid = 1'b1; redirect_pc = redir_tgt; redir_when = 0;
    end else if ($urandom_range(99) < p_redir) begin
      redirect_valid = 1'b1; redirect_pc = rand_tgt();
    end

    if (ifu_r_valid && s_r_ready) begin out_cnt--; clr_r = 1; end
    if (s_ar_valid && ifu_ar_ready) begin
      chk("one_ar", 64'(out_cnt), 64'(0));
      chk("ar_align", 64'(s_ar_addr[2:0]), 64'(0));
      out_cnt++;
      beat_addr = s_ar_addr;
      beat_dly = int'($urandom_range(rmax, rmin));
    end
    if (redirect_valid) exp_pc = redirect_pc & ~64'h3;
    else if (s_id_valid && id_ready) begin
      chk("id_pc", s_id_pc, exp_pc);
      chk("id_inst", 64'(s_id_inst), 64'(exp_inst(exp_pc)));
      chk("id_fault", 64'(s_id_fault), 64'(is_err(exp_pc)));
      exp_pc = exp_pc + 64'd4;
      n_acc++;
    end
    prev_ar_stall = s_ar_valid && !ifu_ar_ready;
    prev_ar_addr  = s_ar_addr;
  endtask

  task automatic wait_for(input int which, output bit saw_id);
    bit hit;
    saw_id = 0; hit = 0;
    for (int n = 0; n < 100 && !hit; n++) begin
      step();
      if (s_id_valid) saw_id = 1;
      case (which)
        0:       hit = s_ar_valid;
        1:       hit = s_r_ready;
        default: hit = s_id_valid;
      endcase
    end
    if (!hit) chk("wait_timeout", 64'(hit), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ifu_ar_ready = 0; ifu_r_valid = 0; id_ready = 0; redirect_valid = 0;
    out_cnt = 0; clr_r = 0; prev_ar_stall = 0; redir_when = 0;
    @(negedge clk);
    chk("rst_ar_valid", 64'(ifu_ar_valid), 64'(0));
    chk("rst_r_ready", 64'(ifu_r_ready), 64'(0));
    chk("rst_id_valid", 64'(id_valid), 64'(0));
    chk("rst_id_inst", 64'(id_inst), 64'(0));
    chk("rst_id_fault", 64'(id_fault), 64'(0));
    chk("rst_id_pc", id_pc, 64'h8000_0000);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 64'h8000_0000;
    chk("idle_no_ar", 64'(ifu_ar_valid), 64'(0));
  endtask

  initial begin
    bit saw;
    logic [63:0] a0;

    // reset release and first request
    do_reset();
    step();
    chk("t1_ar_valid", 64'(s_ar_valid), 64'(1));
    chk("t1_ar_addr", s_ar_addr, 64'h8000_0000);

    // word select: second instruction comes from the upper half of the same beat
    wait_for(2, saw);
    p_idr = 0;
    wait_for(2, saw);
    chk("t2_ar_addr", beat_addr, 64'h8000_0000);
    chk("t2_id_pc", s_id_pc, 64'h8000_0004);
    chk("t2_id_inst", 64'(s_id_inst), 64'h1111_2222);

    // ID back-pressure
    repeat (5) begin
      step();
      chk("t3_id_valid", 64'(s_id_valid), 64'(1));
      chk("t3_id_inst", 64'(s_id_inst), 64'h1111_2222);
      chk("t3_no_ar", 64'(s_ar_valid), 64'(0));
    end
    p_idr = 100; rmin = 3; rmax = 3;
    wait_for(0, saw);
    chk("t3_next_ar", s_ar_addr, 64'h8000_0008);

    // redirect while waiting for a delayed beat
    redir_tgt = 64'h8000_1000; redir_when = 1;
    wait_for(0, saw);
    chk("t4_no_id", 64'(saw), 64'(0));
    chk("t4_ar_addr", s_ar_addr, 64'h8000_1000);

    // redirect while AR is stalled
    rmin = 0; rmax = 0;
    wait_for(2, saw);
    p_arr = 0;
    wait_for(0, saw);
    a0 = s_ar_addr;
    chk("t5_ar_old", a0, 64'h8000_1000);
    redir_tgt = 64'h8000_3000; redir_when = 2;
    repeat (3) begin
      step();
      chk("t5_hold_v", 64'(s_ar_valid), 64'(1));
      chk("t5_hold_a", s_ar_addr, a0);
    end
    p_arr = 100;
    wait_for(1, saw);
    wait_for(0, saw);
    chk("t5_no_id", 64'(saw), 64'(0));
    chk("t5_ar_new", s_ar_addr, 64'h8000_3000);

    // error response, then OKAY
    redir_tgt = 64'h8000_4150; redir_when = 3;
    wait_for(2, saw);
    chk("t6_pc", s_id_pc, 64'h8000_4150);
    chk("t6_fault", 64'(s_id_fault), 64'(1));
    wait_for(2, saw);
    wait_for(2, saw);
    chk("t6_ok_pc", s_id_pc, 64'h8000_4158);
    chk("t6_ok_fault", 64'(s_id_fault), 64'(0));

    // unaligned target bits ignored, pc wrap
    redir_tgt = 64'hFFFF_FFFF_FFFF_FFFE; redir_when = 3;
    wait_for(2, saw);
    chk("t7_top_pc", s_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_for(2, saw);
    chk("t7_wrap_pc", s_id_pc, 64'h0);

    // randomized traffic
    n_acc = 0;
    for (int blk = 0; blk < 15; blk++) begin
      p_arr = 30 + int'($urandom_range(70));
      p_idr = 30 + int'($urandom_range(70));
      rmin = 0; rmax = int'($urandom_range(4));
      p_redir = int'($urandom_range(8));
      repeat (200) step();
    end
    chk("progress", 64'(n_acc > 50), 64'(1));

    // mid-transaction reset, then more random traffic
    do_reset();
    p_arr = 100; p_redir = 0;
    wait_for(0, saw);
    chk("rst2_ar_addr", s_ar_addr, 64'h8000_0000);
    n_acc = 0;
    p_arr = 60; p_idr = 60; rmax = 2; p_redir = 4;
    repeat (400) step();
    chk("progress2", 64'(n_acc > 5), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
